// File: rtl/cmp_serial12_pkg.sv
// cmp_serial12_pkg: shared state encoding and sizing helpers for the serial comparator
package cmp_serial12_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int num_digits(int width, int digit);
    return width / digit;
  endfunction
  function automatic bit width_ok(int width, int digit);
    return digit > 0 && width >= digit && width % digit == 0;
  endfunction
endpackage

// File: rtl/cmp_serial12_if.sv
// cmp_serial12_if: request/operand/result bundle for the serial comparator
interface cmp_serial12_if #(parameter int WIDTH = 12);
  logic start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic busy;
  logic done;
  logic Agreater;
  logic Bgreater;
  logic Equall;
  modport master (output start, A, B, input busy, done, Agreater, Bgreater, Equall);
  modport slave (input start, A, B, output busy, done, Agreater, Bgreater, Equall);
endinterface

// File: rtl/cmp_serial12_digit.sv
// cmp_digit: DIGIT-bit unsigned slice comparator with MSB-priority gt/lt
module cmp_digit #(parameter int DIGIT = 4) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic gt,
  output logic lt,
  output logic eq
);
  logic [DIGIT-1:0] e;
  assign e = ~(a ^ b);
  assign eq = &e;
  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    for (int i = 0; i < DIGIT; i++)
      if (!e[i]) begin
        gt = a[i];
        lt = b[i];
      end
  end
endmodule

// File: rtl/cmp_serial12.sv
// cmp_serial12: digit-serial unsigned magnitude comparator, MSB slice first with early exit
module cmp_serial12 import cmp_serial12_pkg::*; #(
  parameter int WIDTH = 12,
  parameter int DIGIT = 4
) (
  input logic clk,
  input logic rst,
  cmp_serial12_if.slave bus
);
  localparam int ND = num_digits(WIDTH, DIGIT);
  localparam int IW = ND > 1 ? $clog2(ND) : 1;
  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_width
    $fatal(1, "cmp_serial12: WIDTH must be a positive multiple of DIGIT");
  end
  state_t state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0] idx;
  logic [DIGIT-1:0] sa, sb;
  logic gt, lt, eq;
  assign sa = a_q[idx*DIGIT +: DIGIT];
  assign sb = b_q[idx*DIGIT +: DIGIT];
  cmp_digit #(.DIGIT(DIGIT)) u_digit (.a(sa), .b(sb), .gt(gt), .lt(lt), .eq(eq));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      idx <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.Agreater <= 1'b0;
      bus.Bgreater <= 1'b0;
      bus.Equall <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_q <= bus.A;
            b_q <= bus.B;
            idx <= IW'(ND - 1);
            bus.Agreater <= 1'b0;
            bus.Bgreater <= 1'b0;
            bus.Equall <= 1'b0;
            bus.busy <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // eq can only win on the last slice, since any unequal slice decides first
          if (gt || lt || idx == '0) begin
            bus.Agreater <= gt;
            bus.Bgreater <= lt;
            bus.Equall <= eq;
            bus.done <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_serial12.sv
// tb_cmp_serial12: directed and randomised checks of the serial comparator
module tb_cmp_serial12;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  int n;
  always #5 clk = ~clk;
  cmp_serial12_if #(.WIDTH(12)) bus ();
  cmp_serial12 #(.WIDTH(12), .DIGIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] flags();
    return {bus.Agreater, bus.Bgreater, bus.Equall};
  endfunction

  task automatic go(input logic [11:0] a, input logic [11:0] b);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.done && lat < 12) begin
      step();
      lat++;
    end
  endtask

  function automatic int ref_lat(input logic [11:0] a, input logic [11:0] b);
    for (int k = 0; k < 3; k++)
      if (a[11-4*k -: 4] != b[11-4*k -: 4]) return k + 2;
    return 4;
  endfunction

  function automatic logic [2:0] ref_flags(input logic [11:0] a, input logic [11:0] b);
    return {a > b, a < b, a == b};
  endfunction

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    step();
    step();
    chk("reset_busy", 12'(bus.busy), 12'h0);
    chk("reset_done", 12'(bus.done), 12'h0);
    chk("reset_flags", 12'(flags()), 12'h0);
    rst = 1'b0;
    step();
    // top slice decides: done two cycles after t0
    go(12'hA53, 12'h3FF);
    chk("t1_run_busy", 12'(bus.busy), 12'h1);
    chk("t1_run_done", 12'(bus.done), 12'h0);
    chk("t1_run_flags", 12'(flags()), 12'h0);
    step();
    chk("t1_done", 12'(bus.done), 12'h1);
    chk("t1_flags", 12'(flags()), 12'b100);
    step();
    chk("t1_busy_low", 12'(bus.busy), 12'h0);
    chk("t1_done_pulse", 12'(bus.done), 12'h0);
    chk("t1_flags_hold", 12'(flags()), 12'b100);
    // second slice decides
    go(12'h5A3, 12'h5B0);
    step();
    chk("t2_not_yet", 12'(bus.done), 12'h0);
    chk("t2_run_flags", 12'(flags()), 12'h0);
    step();
    chk("t2_done", 12'(bus.done), 12'h1);
    chk("t2_flags", 12'(flags()), 12'b010);
    step();
    // all slices equal; a start during RUN/DONE is ignored
    go(12'h7C1, 12'h7C1);
    bus.A = 12'h000;
    bus.B = 12'hFFF;
    bus.start = 1'b1;
    step();
    step();
    chk("t3_not_yet", 12'(bus.done), 12'h0);
    step();
    chk("t3_done", 12'(bus.done), 12'h1);
    chk("t3_flags", 12'(flags()), 12'b001);
    bus.start = 1'b0;
    step();
    step();
    chk("t3_ignored_busy", 12'(bus.busy), 12'h0);
    chk("t3_ignored_flags", 12'(flags()), 12'b001);
    // reset mid-compare abandons without a done pulse
    go(12'hFFF, 12'hFFF);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_rst_busy", 12'(bus.busy), 12'h0);
    chk("t4_rst_done", 12'(bus.done), 12'h0);
    chk("t4_rst_flags", 12'(flags()), 12'h0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      n += int'(bus.done);
    end
    chk("t4_no_done", 12'(n), 12'h0);
    go(12'h123, 12'h124);
    wait_done(n);
    chk("t4_lat", 12'(n), 12'd4);
    chk("t4_flags", 12'(flags()), 12'b010);
    step();
    // flags hold while idle, clear on the next acceptance
    go(12'h001, 12'h000);
    wait_done(n);
    chk("t5_lat", 12'(n), 12'd4);
    chk("t5_flags", 12'(flags()), 12'b100);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      n += int'(flags() == 3'b100);
    end
    chk("t5_hold", 12'(n), 12'd6);
    go(12'h000, 12'h001);
    chk("t5_cleared", 12'(flags()), 12'h0);
    wait_done(n);
    chk("t5b_lat", 12'(n), 12'd4);
    chk("t5b_flags", 12'(flags()), 12'b010);
    step();
    // randomised pairs; b often shares upper slices with a to exercise later slices
    for (int t = 0; t < 1000; t++) begin
      logic [11:0] a, b;
      a = 12'($urandom_range(0, 4095));
      b = 12'($urandom_range(0, 4095));
      case ($urandom_range(0, 3))
        0: b[11:4] = a[11:4];
        1: b[11:8] = a[11:8];
        2: b = a;
        default: ;
      endcase
      for (int g = $urandom_range(0, 3); g > 0; g--) step();
      go(a, b);
      wait_done(n);
      chk("rnd_lat", 12'(n), 12'(ref_lat(a, b)));
      chk("rnd_flags", 12'(flags()), 12'(ref_flags(a, b)));
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
